// File: rtl/m00_axi_master_if.sv
// AXI4-Lite bus between m00_axi_master and its slave; widths follow the master's parameters.
interface m00_axi_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 10
) ();
    logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                  M_AXI_AWPROT;
    logic                        M_AXI_AWVALID;
    logic                        M_AXI_AWREADY;
    logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                        M_AXI_WVALID;
    logic                        M_AXI_WREADY;
    logic [1:0]                  M_AXI_BRESP;
    logic                        M_AXI_BVALID;
    logic                        M_AXI_BREADY;
    logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                  M_AXI_ARPROT;
    logic                        M_AXI_ARVALID;
    logic                        M_AXI_ARREADY;
    logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                  M_AXI_RRESP;
    logic                        M_AXI_RVALID;
    logic                        M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/m00_axi_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into one AXI read or write
// and returns the completion on rsp_*.
module m00_axi_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 10
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
    m00_axi_master_if.master            m_axi
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        write_q;
    logic                        awvalid_q;
    logic                        wvalid_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                  resp_q;
    logic                        aw_fire;
    logic                        w_fire;

    assign aw_fire = awvalid_q && m_axi.M_AXI_AWREADY;
    assign w_fire  = wvalid_q && m_axi.M_AXI_WREADY;

    // NOTE: cmd_ready is gated by reset so a command held during reset is never acknowledged.
    assign cmd_ready = (state == IDLE) && !AXI_ARESET;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = (state == WR_RESP);
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = (state == RD_REQ);
    assign m_axi.M_AXI_RREADY  = (state == RD_DATA);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        write_q <= cmd_write;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; leave once neither is still pending.
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        resp_q  <= m_axi.M_AXI_BRESP;
                        rdata_q <= '0;
                        state   <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_axi.M_AXI_ARREADY) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rdata_q <= m_axi.M_AXI_RDATA;
                        resp_q  <= m_axi.M_AXI_RRESP;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
